// File: rtl/chi_rn_txn_tracker.sv
// chi_rn_txn_tracker
//
// Purpose:
//   CHI request-node transaction engine. It accepts core requests (ReadShared, WriteBack and
//   WriteUnique) and allocates a tracker entry from a pool of NUM_OUT. The entry index is used
//   as the txn_id. The module serialises a REQ flit, plus a DATA flit for writes, onto the TX
//   channel. Entries retire on a matching RX completion flit or on timeout.
//
// Encodings:
//   req/tx/cpl opcode : 0 = ReadShared, 1 = WriteBack, 2 = WriteUnique, 3..15 illegal
//   flit type         : 0 = FLIT_REQ, 1 = FLIT_RSP, 2 = FLIT_DATA
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/ready/opcode/addr/data core request port
//   tx_flit_*                       outgoing flit channel (valid/ready handshake)
//   rx_flit_valid/type/txn_id/data  incoming completion flits (always accepted)
//   cpl_*                           one-cycle completion report (no backpressure)
//   busy_count                      number of allocated tracker entries
//   err_illegal_op                  sticky flag: an illegal opcode was accepted and dropped
module chi_rn_txn_tracker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NODE_W  = 4,
    parameter int TXN_W   = 8,
    parameter int NUM_OUT = 4,
    parameter int SRC_ID  = 0,
    parameter int HOME_ID = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [3:0]                     req_opcode,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [DATA_W-1:0]              req_data,
    output logic                           tx_flit_valid,
    input  logic                           tx_flit_ready,
    output logic [1:0]                     tx_flit_type,
    output logic [3:0]                     tx_opcode,
    output logic [ADDR_W-1:0]              tx_addr,
    output logic [TXN_W-1:0]               tx_txn_id,
    output logic [DATA_W-1:0]              tx_data,
    output logic [NODE_W-1:0]              tx_src_id,
    output logic [NODE_W-1:0]              tx_tgt_id,
    input  logic                           rx_flit_valid,
    input  logic [1:0]                     rx_flit_type,
    input  logic [TXN_W-1:0]               rx_txn_id,
    input  logic [DATA_W-1:0]              rx_data,
    output logic                           cpl_valid,
    output logic [TXN_W-1:0]               cpl_txn_id,
    output logic [3:0]                     cpl_opcode,
    output logic [DATA_W-1:0]              cpl_data,
    output logic                           cpl_error,
    output logic [$clog2(NUM_OUT+1)-1:0]   busy_count,
    output logic                           err_illegal_op
);

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int CNT_W = $clog2(NUM_OUT + 1);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    localparam logic [3:0] OP_READ_SHARED = 4'd0;
    localparam logic [3:0] OP_MAX_LEGAL   = 4'd2;
    localparam logic [1:0] FLIT_REQ  = 2'd0;
    localparam logic [1:0] FLIT_RSP  = 2'd1;
    localparam logic [1:0] FLIT_DATA = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND_REQ  = 2'd1,
        S_SEND_DATA = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // Fields of the transaction currently being serialised on TX
    logic [IDX_W-1:0]    r_cur_idx;
    logic [3:0]          r_cur_op;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [DATA_W-1:0]   r_cur_data;

    // Tracker entries
    logic [NUM_OUT-1:0]  r_alloc;
    logic [NUM_OUT-1:0]  r_armed;
    logic [3:0]          r_ent_op [NUM_OUT];
    logic [TMR_W-1:0]    r_timer  [NUM_OUT];

    logic [CNT_W-1:0]    r_busy;
    logic                r_err_illegal;
    logic                r_cpl_valid;
    logic [TXN_W-1:0]    r_cpl_txn_id;
    logic [3:0]          r_cpl_opcode;
    logic [DATA_W-1:0]   r_cpl_data;
    logic                r_cpl_error;

    logic [NUM_OUT-1:0]  w_free_vec;
    logic [NUM_OUT-1:0]  w_expired;
    logic [NUM_OUT-1:0]  w_rx_hit;
    logic [NUM_OUT-1:0]  w_release_vec;
    logic                w_any_free;
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_rx_any_hit;
    logic [IDX_W-1:0]    w_rx_idx;
    logic                w_to_valid;
    logic [IDX_W-1:0]    w_to_idx;
    logic                w_op_legal;
    logic                w_req_fire;
    logic                w_alloc;
    logic                w_tx_fire;
    logic                w_last_flit;
    logic                w_arm;
    logic                w_any_release;

    // Per-entry status: ids are unique, so at most one entry can hit an RX flit.
    // A timeout is only reported in a cycle with no RX flit, because RX owns the cpl slot.
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_entry
        assign w_free_vec[gi]    = ~r_alloc[gi];
        assign w_expired[gi]     = (TIMEOUT != 0) && r_armed[gi] && (r_timer[gi] == TMR_MAX);
        assign w_rx_hit[gi]      = rx_flit_valid && r_armed[gi] &&
                                   (rx_txn_id == TXN_W'(gi)) &&
                                   ((r_ent_op[gi] == OP_READ_SHARED) ? (rx_flit_type == FLIT_DATA)
                                                                     : (rx_flit_type == FLIT_RSP));
        assign w_release_vec[gi] = w_rx_hit[gi] | (w_to_valid && (w_to_idx == IDX_W'(gi)));
    end

    // Lowest-index priority encoders
    always_comb begin
        w_free_idx   = '0;
        w_rx_idx     = '0;
        w_to_idx     = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (w_free_vec[i]) w_free_idx = IDX_W'(i);
            if (w_rx_hit[i])   w_rx_idx   = IDX_W'(i);
            if (w_expired[i])  w_to_idx   = IDX_W'(i);
        end
        w_any_free   = |w_free_vec;
        w_rx_any_hit = |w_rx_hit;
        w_to_valid   = !rx_flit_valid && (|w_expired);
    end

    assign w_op_legal    = (req_opcode <= OP_MAX_LEGAL);
    assign w_req_fire    = req_valid && req_ready;
    assign w_alloc       = w_req_fire && w_op_legal;
    assign w_tx_fire     = tx_flit_valid && tx_flit_ready;
    assign w_last_flit   = (r_state == S_SEND_DATA) ||
                           ((r_state == S_SEND_REQ) && (r_cur_op == OP_READ_SHARED));
    assign w_arm         = w_tx_fire && w_last_flit;
    assign w_any_release = |w_release_vec;

    // ---------------- TX FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // ---------------- TX FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_alloc) w_state_next = S_SEND_REQ;
            S_SEND_REQ:  if (tx_flit_ready)
                             w_state_next = (r_cur_op == OP_READ_SHARED) ? S_IDLE : S_SEND_DATA;
            S_SEND_DATA: if (tx_flit_ready) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // ---------------- TX FSM: outputs ----------------
    // Fields come from the captured registers, so they stay stable while the flit is stalled.
    always_comb begin
        req_ready     = 1'b0;
        tx_flit_valid = 1'b0;
        tx_flit_type  = FLIT_REQ;
        tx_opcode     = '0;
        tx_addr       = '0;
        tx_txn_id     = '0;
        tx_data       = '0;
        tx_src_id     = '0;
        tx_tgt_id     = '0;
        if (!rst) begin
            req_ready = (r_state == S_IDLE) && w_any_free;
            if (r_state != S_IDLE) begin
                tx_flit_valid = 1'b1;
                tx_opcode     = r_cur_op;
                tx_addr       = r_cur_addr;
                tx_txn_id     = TXN_W'(r_cur_idx);
                tx_src_id     = NODE_W'(SRC_ID);
                tx_tgt_id     = NODE_W'(HOME_ID);
                if (r_state == S_SEND_DATA) begin
                    tx_flit_type = FLIT_DATA;
                    tx_data      = r_cur_data;
                end
            end
        end
    end

    // Capture of the request being serialised
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_idx  <= '0;
            r_cur_op   <= '0;
            r_cur_addr <= '0;
            r_cur_data <= '0;
        end else if (w_alloc) begin
            r_cur_idx  <= w_free_idx;
            r_cur_op   <= req_opcode;
            r_cur_addr <= req_addr;
            r_cur_data <= req_data;
        end
    end

    // Entry lifecycle: free -> allocated -> armed -> free.
    // The timer starts at 1 on arming so an entry is reported TIMEOUT cycles after its last flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc <= '0;
            r_armed <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                r_ent_op[i] <= '0;
                r_timer[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_alloc && (w_free_idx == IDX_W'(i))) begin
                    r_alloc[i]  <= 1'b1;
                    r_armed[i]  <= 1'b0;
                    r_ent_op[i] <= req_opcode;
                    r_timer[i]  <= '0;
                end else if (w_release_vec[i]) begin
                    r_alloc[i]  <= 1'b0;
                    r_armed[i]  <= 1'b0;
                    r_timer[i]  <= '0;
                end else if (w_arm && (r_cur_idx == IDX_W'(i))) begin
                    r_armed[i]  <= 1'b1;
                    r_timer[i]  <= TMR_W'(1);
                end else if (r_armed[i] && (TIMEOUT != 0) && (r_timer[i] != TMR_MAX)) begin
                    r_timer[i]  <= r_timer[i] + TMR_W'(1);
                end
            end
        end
    end

    // Occupancy counter and sticky illegal-opcode flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_err_illegal <= 1'b0;
        end else begin
            case ({w_alloc, w_any_release})
                2'b10:   r_busy <= r_busy + CNT_W'(1);
                2'b01:   r_busy <= r_busy - CNT_W'(1);
                default: r_busy <= r_busy;
            endcase
            if (w_req_fire && !w_op_legal) r_err_illegal <= 1'b1;
        end
    end

    // Completion slot: an RX result always takes it; otherwise the lowest expired entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpl_valid  <= 1'b0;
            r_cpl_txn_id <= '0;
            r_cpl_opcode <= '0;
            r_cpl_data   <= '0;
            r_cpl_error  <= 1'b0;
        end else if (rx_flit_valid) begin
            r_cpl_valid  <= 1'b1;
            r_cpl_txn_id <= rx_txn_id;
            if (w_rx_any_hit) begin
                r_cpl_opcode <= r_ent_op[w_rx_idx];
                r_cpl_data   <= (r_ent_op[w_rx_idx] == OP_READ_SHARED) ? rx_data : '0;
                r_cpl_error  <= 1'b0;
            end else begin
                r_cpl_opcode <= '0;
                r_cpl_data   <= '0;
                r_cpl_error  <= 1'b1;
            end
        end else if (w_to_valid) begin
            r_cpl_valid  <= 1'b1;
            r_cpl_txn_id <= TXN_W'(w_to_idx);
            r_cpl_opcode <= r_ent_op[w_to_idx];
            r_cpl_data   <= '0;
            r_cpl_error  <= 1'b1;
        end else begin
            r_cpl_valid  <= 1'b0;
            r_cpl_txn_id <= '0;
            r_cpl_opcode <= '0;
            r_cpl_data   <= '0;
            r_cpl_error  <= 1'b0;
        end
    end

    assign busy_count     = r_busy;
    assign err_illegal_op = r_err_illegal;
    assign cpl_valid      = r_cpl_valid;
    assign cpl_txn_id     = r_cpl_txn_id;
    assign cpl_opcode     = r_cpl_opcode;
    assign cpl_data       = r_cpl_data;
    assign cpl_error      = r_cpl_error;

endmodule

// File: tb/tb_chi_rn_txn_tracker.sv
// tb_chi_rn_txn_tracker
//
// Purpose: directed, table-driven bench for chi_rn_txn_tracker (TIMEOUT = 8).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_chi_rn_txn_tracker;

    localparam logic [3:0] OP_RS = 4'd0;
    localparam logic [3:0] OP_WB = 4'd1;
    localparam logic [3:0] OP_WU = 4'd2;
    localparam logic [1:0] FT_REQ  = 2'd0;
    localparam logic [1:0] FT_RSP  = 2'd1;
    localparam logic [1:0] FT_DATA = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        tx_flit_valid;
    logic        tx_flit_ready;
    logic [1:0]  tx_flit_type;
    logic [3:0]  tx_opcode;
    logic [31:0] tx_addr;
    logic [7:0]  tx_txn_id;
    logic [31:0] tx_data;
    logic [3:0]  tx_src_id;
    logic [3:0]  tx_tgt_id;
    logic        rx_flit_valid;
    logic [1:0]  rx_flit_type;
    logic [7:0]  rx_txn_id;
    logic [31:0] rx_data;
    logic        cpl_valid;
    logic [7:0]  cpl_txn_id;
    logic [3:0]  cpl_opcode;
    logic [31:0] cpl_data;
    logic        cpl_error;
    logic [2:0]  busy_count;
    logic        err_illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    chi_rn_txn_tracker #(
        .ADDR_W(32), .DATA_W(32), .NODE_W(4), .TXN_W(8), .NUM_OUT(4),
        .SRC_ID(0), .HOME_ID(1), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_data(req_data),
        .tx_flit_valid(tx_flit_valid), .tx_flit_ready(tx_flit_ready), .tx_flit_type(tx_flit_type),
        .tx_opcode(tx_opcode), .tx_addr(tx_addr), .tx_txn_id(tx_txn_id), .tx_data(tx_data),
        .tx_src_id(tx_src_id), .tx_tgt_id(tx_tgt_id),
        .rx_flit_valid(rx_flit_valid), .rx_flit_type(rx_flit_type), .rx_txn_id(rx_txn_id),
        .rx_data(rx_data),
        .cpl_valid(cpl_valid), .cpl_txn_id(cpl_txn_id), .cpl_opcode(cpl_opcode),
        .cpl_data(cpl_data), .cpl_error(cpl_error),
        .busy_count(busy_count), .err_illegal_op(err_illegal_op)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;      // cycles tx_flit_ready is held low on the REQ flit
        logic [1:0]  rx_type;
        logic [31:0] rx_data;
        logic        exp_err;    // 1: RX does not match, entry later times out
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] flit_now();
        return 128'({tx_flit_valid, tx_flit_type, tx_opcode, tx_addr, tx_txn_id, tx_data,
                     tx_src_id, tx_tgt_id});
    endfunction

    function automatic logic [127:0] flit_exp(input logic [1:0] t, input logic [3:0] op,
                                              input logic [31:0] a, input logic [7:0] id,
                                              input logic [31:0] d);
        return 128'({1'b1, t, op, a, id, d, 4'd0, 4'd1});
    endfunction

    function automatic logic [127:0] cpl_now();
        return 128'({cpl_valid, cpl_txn_id, cpl_opcode, cpl_data, cpl_error, busy_count});
    endfunction

    function automatic logic [127:0] cpl_exp(input logic [7:0] id, input logic [3:0] op,
                                             input logic [31:0] d, input logic err,
                                             input logic [2:0] busy);
        return 128'({1'b1, id, op, d, err, busy});
    endfunction

    // Starts and ends just after a rising edge.
    task automatic issue_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        int k = 0;
        req_valid  = 1'b1;
        req_opcode = op;
        req_addr   = a;
        req_data   = d;
        @(negedge clk);
        while (!req_ready && k < 10) begin
            step();
            @(negedge clk);
            k++;
        end
        check("req_ready", 128'(req_ready), 128'(1'b1));
        step();
        req_valid  = 1'b0;
        req_opcode = '0;
        req_addr   = '0;
        req_data   = '0;
        $display("txn: request op=%0d addr=0x%0h data=0x%0h", op, a, d);
    endtask

    task automatic expect_flit(input string name, input logic [127:0] exp, input int stall);
        int k = 0;
        tx_flit_ready = (stall == 0);
        @(negedge clk);
        while (!tx_flit_valid && k < 10) begin
            step();
            @(negedge clk);
            k++;
        end
        check(name, flit_now(), exp);
        for (int s = 0; s < stall; s++) begin
            step();
            if (s == stall - 1) tx_flit_ready = 1'b1;
            @(negedge clk);
            check({name, "_hold"}, flit_now(), exp);
        end
        step();
        tx_flit_ready = 1'b1;
    endtask

    task automatic expect_cpl(input string name, input logic [127:0] exp, input int max_wait);
        int k = 0;
        @(negedge clk);
        while (!cpl_valid && k < max_wait) begin
            step();
            @(negedge clk);
            k++;
        end
        check(name, cpl_now(), exp);
        $display("txn: completion id=%0d op=%0d err=%0d data=0x%0h busy=%0d",
                 cpl_txn_id, cpl_opcode, cpl_error, cpl_data, busy_count);
        step();
    endtask

    task automatic send_rx(input logic [1:0] t, input logic [7:0] id, input logic [31:0] d,
                           input string name, input logic [127:0] exp);
        rx_flit_valid = 1'b1;
        rx_flit_type  = t;
        rx_txn_id     = id;
        rx_data       = d;
        step();
        rx_flit_valid = 1'b0;
        rx_flit_type  = '0;
        rx_txn_id     = '0;
        rx_data       = '0;
        expect_cpl(name, exp, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        vec_t v;

        vecs[0] = '{OP_RS, 32'h1000, 32'hDEAD, 0, FT_DATA, 32'hCAFE, 1'b0, 32'hCAFE};
        vecs[1] = '{OP_WU, 32'h2000, 32'h55,   3, FT_RSP,  32'h0,    1'b0, 32'h0};
        vecs[2] = '{OP_WB, 32'h3000, 32'hA5A5, 1, FT_RSP,  32'h77,   1'b0, 32'h0};
        vecs[3] = '{OP_RS, 32'h4000, 32'h0,    0, FT_RSP,  32'h99,   1'b1, 32'h0};
        vecs[4] = '{OP_WB, 32'h5000, 32'h11,   0, FT_DATA, 32'h22,   1'b1, 32'h0};

        rst = 1'b1;
        req_valid = 1'b0; req_opcode = '0; req_addr = '0; req_data = '0;
        tx_flit_ready = 1'b1;
        // RX traffic during reset must be ignored
        rx_flit_valid = 1'b1; rx_flit_type = FT_DATA; rx_txn_id = '0; rx_data = 32'h1234;

        repeat (3) step();
        @(negedge clk);
        check("reset_outputs",
              128'({req_ready, tx_flit_valid, cpl_valid, cpl_error, busy_count, err_illegal_op,
                    tx_src_id, tx_tgt_id}), 128'(0));
        step();
        rst = 1'b0;
        rx_flit_valid = 1'b0;
        @(negedge clk);
        check("post_reset", 128'({req_ready, busy_count, cpl_valid}), 128'({1'b1, 3'd0, 1'b0}));
        step();

        // Table-driven single transactions
        for (int r = 0; r < 5; r++) begin
            v = vecs[r];
            issue_req(v.op, v.addr, v.data);
            expect_flit("req_flit", flit_exp(FT_REQ, v.op, v.addr, 8'd0, 32'd0), v.stall);
            if (v.op != OP_RS)
                expect_flit("data_flit", flit_exp(FT_DATA, v.op, v.addr, 8'd0, v.data), 0);
            send_rx(v.rx_type, 8'd0, v.rx_data, "rx_cpl",
                    cpl_exp(8'd0, v.exp_err ? 4'd0 : v.op, v.exp_data, v.exp_err,
                            v.exp_err ? 3'd1 : 3'd0));
            if (v.exp_err)
                expect_cpl("timeout_cpl", cpl_exp(8'd0, v.op, 32'd0, 1'b1, 3'd0), 20);
        end

        // Pool exhaustion, wrong-type RSP, then four timeouts in index order
        for (int i = 0; i < 4; i++) begin
            issue_req(OP_RS, 32'h8000 + 32'(i * 64), 32'd0);
            expect_flit("fill_req_flit", flit_exp(FT_REQ, OP_RS, 32'h8000 + 32'(i * 64), 8'(i), 32'd0), 0);
        end
        @(negedge clk);
        check("full_pool", 128'({req_ready, busy_count}), 128'({1'b0, 3'd4}));
        send_rx(FT_RSP, 8'd2, 32'd0, "full_wrong_type", cpl_exp(8'd2, 4'd0, 32'd0, 1'b1, 3'd4));
        for (int i = 0; i < 4; i++)
            expect_cpl("full_timeout", cpl_exp(8'(i), OP_RS, 32'd0, 1'b1, 3'(3 - i)), 20);

        // Timeout latency: report exactly 8 cycles after the arming handshake
        issue_req(OP_RS, 32'h7000, 32'd0);
        expect_flit("lat_req_flit", flit_exp(FT_REQ, OP_RS, 32'h7000, 8'd0, 32'd0), 0);
        cycles = 0;
        @(negedge clk);
        while (!cpl_valid && cycles < 20) begin
            step();
            cycles++;
            @(negedge clk);
        end
        check("timeout_latency", 128'(cycles), 128'(8));
        check("timeout_fields", cpl_now(), cpl_exp(8'd0, OP_RS, 32'd0, 1'b1, 3'd0));
        step();

        // RX match on id1 in the same cycle id0 expires
        issue_req(OP_RS, 32'h9000, 32'd0);
        expect_flit("race_req0", flit_exp(FT_REQ, OP_RS, 32'h9000, 8'd0, 32'd0), 0);
        issue_req(OP_RS, 32'h9040, 32'd0);
        expect_flit("race_req1", flit_exp(FT_REQ, OP_RS, 32'h9040, 8'd1, 32'd0), 0);
        repeat (5) step();
        @(negedge clk);
        check("no_early_timeout", 128'(cpl_valid), 128'(1'b0));
        send_rx(FT_DATA, 8'd1, 32'hBEEF, "race_rx", cpl_exp(8'd1, OP_RS, 32'hBEEF, 1'b0, 3'd1));
        expect_cpl("race_timeout", cpl_exp(8'd0, OP_RS, 32'd0, 1'b1, 3'd0), 0);

        // Illegal opcode: accepted, dropped, sticky flag
        issue_req(4'hF, 32'hA000, 32'd0);
        @(negedge clk);
        check("illegal_op", 128'({tx_flit_valid, err_illegal_op, busy_count}),
              128'({1'b0, 1'b1, 3'd0}));
        step();
        @(negedge clk);
        check("illegal_idle", 128'({tx_flit_valid, req_ready, err_illegal_op}),
              128'({1'b0, 1'b1, 1'b1}));
        step();

        // Reset in the middle of SEND_DATA, with an RX flit presented during reset
        issue_req(OP_WB, 32'h6000, 32'h77);
        expect_flit("rst_req_flit", flit_exp(FT_REQ, OP_WB, 32'h6000, 8'd0, 32'd0), 0);
        tx_flit_ready = 1'b0;
        @(negedge clk);
        check("rst_data_flit", flit_now(), flit_exp(FT_DATA, OP_WB, 32'h6000, 8'd0, 32'h77));
        rst = 1'b1;
        rx_flit_valid = 1'b1; rx_flit_type = FT_RSP; rx_txn_id = 8'd0;
        step();
        @(negedge clk);
        check("mid_reset", 128'({tx_flit_valid, busy_count, cpl_valid, req_ready, err_illegal_op}),
              128'(0));
        step();
        rst = 1'b0;
        rx_flit_valid = 1'b0;
        tx_flit_ready = 1'b1;
        @(negedge clk);
        check("after_mid_reset", 128'({req_ready, busy_count, err_illegal_op, tx_flit_valid}),
              128'({1'b1, 3'd0, 1'b0, 1'b0}));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
